// File: rtl/align_if.sv
// Handshake and operand/result bus of the exponent-alignment scheduler.
interface align_if #(
  parameter int FRAC_W = 18,
  parameter int EXP_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [EXP_W-1:0]  a_exp;
  logic [EXP_W-1:0]  b_exp;
  logic [FRAC_W-1:0] a_frac;
  logic [FRAC_W-1:0] b_frac;
  logic              out_valid;
  logic              out_ready;
  logic [EXP_W-1:0]  out_exp;
  logic [FRAC_W-1:0] big_frac;
  logic [FRAC_W-1:0] small_frac;
  logic              sticky;
  logic              swapped;

  modport master (
    output in_valid, a_exp, b_exp, a_frac, b_frac, out_ready,
    input  in_ready, out_valid, out_exp, big_frac, small_frac, sticky, swapped
  );

  modport slave (
    input  in_valid, a_exp, b_exp, a_frac, b_frac, out_ready,
    output in_ready, out_valid, out_exp, big_frac, small_frac, sticky, swapped
  );
endinterface

// File: rtl/align_scheduler.sv
// Aligns two floating-point operands to the larger exponent: IDLE -> CMP -> SHIFT -> HOLD.
module align_scheduler #(
  parameter int FRAC_W = 18,
  parameter int EXP_W  = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  align_if.slave io
);
  typedef enum logic [1:0] {IDLE, CMP, SHIFT, HOLD} state_t;

  localparam logic [31:0] FRAC_W_U = FRAC_W;

  state_t            state_q, state_d;
  logic [EXP_W-1:0]  a_exp_q, a_exp_d, b_exp_q, b_exp_d;
  logic [FRAC_W-1:0] a_frac_q, a_frac_d, b_frac_q, b_frac_d;
  logic [EXP_W-1:0]  big_exp_q, big_exp_d, diff_q, diff_d;
  logic [FRAC_W-1:0] big_fr_q, big_fr_d, sml_fr_q, sml_fr_d;
  logic              swap_q, swap_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;
  logic [FRAC_W-1:0] big_frac_q, big_frac_d, small_frac_q, small_frac_d;
  logic              sticky_q, sticky_d, swapped_q, swapped_d;

  logic [FRAC_W-1:0] sh_res, sh_mask;
  logic              sh_sticky;
  logic [31:0]       diff_ext;

  assign diff_ext = 32'(diff_q);

  // Logical right shifter; sticky collects every bit that falls off the LSB end.
  always_comb begin
    sh_res    = sml_fr_q;
    sh_sticky = 1'b0;
    sh_mask   = '0;
    if (diff_q == '0) begin
      sh_res    = sml_fr_q;
      sh_sticky = 1'b0;
    end else if (diff_ext >= FRAC_W_U) begin
      sh_res    = '0;
      sh_sticky = |sml_fr_q;
    end else begin
      sh_res    = sml_fr_q >> diff_q;
      sh_mask   = ~({FRAC_W{1'b1}} << diff_q);
      sh_sticky = |(sml_fr_q & sh_mask);
    end
  end

  always_comb begin
    state_d      = state_q;
    a_exp_d      = a_exp_q;
    b_exp_d      = b_exp_q;
    a_frac_d     = a_frac_q;
    b_frac_d     = b_frac_q;
    big_exp_d    = big_exp_q;
    diff_d       = diff_q;
    big_fr_d     = big_fr_q;
    sml_fr_d     = sml_fr_q;
    swap_d       = swap_q;
    out_exp_d    = out_exp_q;
    big_frac_d   = big_frac_q;
    small_frac_d = small_frac_q;
    sticky_d     = sticky_q;
    swapped_d    = swapped_q;
    unique case (state_q)
      IDLE: if (io.in_valid) begin
        a_exp_d  = io.a_exp;
        b_exp_d  = io.b_exp;
        a_frac_d = io.a_frac;
        b_frac_d = io.b_frac;
        state_d  = CMP;
      end
      CMP: begin
        // Ties keep a as the big operand.
        if (b_exp_q > a_exp_q) begin
          swap_d    = 1'b1;
          big_exp_d = b_exp_q;
          big_fr_d  = b_frac_q;
          sml_fr_d  = a_frac_q;
          diff_d    = b_exp_q - a_exp_q;
        end else begin
          swap_d    = 1'b0;
          big_exp_d = a_exp_q;
          big_fr_d  = a_frac_q;
          sml_fr_d  = b_frac_q;
          diff_d    = a_exp_q - b_exp_q;
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        // Result outputs only change here, so they persist through IDLE/CMP.
        out_exp_d    = big_exp_q;
        big_frac_d   = big_fr_q;
        small_frac_d = sh_res;
        sticky_d     = sh_sticky;
        swapped_d    = swap_q;
        state_d      = HOLD;
      end
      HOLD: if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_exp_q      <= '0;
      b_exp_q      <= '0;
      a_frac_q     <= '0;
      b_frac_q     <= '0;
      big_exp_q    <= '0;
      diff_q       <= '0;
      big_fr_q     <= '0;
      sml_fr_q     <= '0;
      swap_q       <= 1'b0;
      out_exp_q    <= '0;
      big_frac_q   <= '0;
      small_frac_q <= '0;
      sticky_q     <= 1'b0;
      swapped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_exp_q      <= a_exp_d;
      b_exp_q      <= b_exp_d;
      a_frac_q     <= a_frac_d;
      b_frac_q     <= b_frac_d;
      big_exp_q    <= big_exp_d;
      diff_q       <= diff_d;
      big_fr_q     <= big_fr_d;
      sml_fr_q     <= sml_fr_d;
      swap_q       <= swap_d;
      out_exp_q    <= out_exp_d;
      big_frac_q   <= big_frac_d;
      small_frac_q <= small_frac_d;
      sticky_q     <= sticky_d;
      swapped_q    <= swapped_d;
    end
  end

  assign io.in_ready   = (state_q == IDLE);
  assign io.out_valid  = (state_q == HOLD);
  assign io.out_exp    = out_exp_q;
  assign io.big_frac   = big_frac_q;
  assign io.small_frac = small_frac_q;
  assign io.sticky     = sticky_q;
  assign io.swapped    = swapped_q;
endmodule

// File: tb/tb_align_scheduler.sv
// Scoreboard bench for align_scheduler: directed operand pairs, stall, mid-flight reset, streaming.
module tb_align_scheduler;
  localparam int FW = 18;
  localparam int EW = 8;

  typedef struct {
    logic [EW-1:0] e;
    logic [FW-1:0] bf;
    logic [FW-1:0] sf;
    logic          st;
    logic          sw;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  align_if #(.FRAC_W(FW), .EXP_W(EW)) bus ();

  align_scheduler #(.FRAC_W(FW), .EXP_W(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   acc_q[$];
  bit   stream_mode = 1'b0;
  int   last_out = -1;
  int   stream_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [EW-1:0] e, input logic [FW-1:0] bf,
                              input logic [FW-1:0] sf, input logic st, input logic sw);
    exp_t r;
    r.e = e; r.bf = bf; r.sf = sf; r.st = st; r.sw = sw;
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: decoupled from stimulus; checks each result once when out_valid rises.
  bit seen = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      seen = 1'b0;
    end else begin
      chk("valid_ready_exclusive", {31'b0, bus.out_valid & bus.in_ready}, 32'd0);
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
      if (bus.out_valid && !seen) begin
        exp_t e;
        seen = 1'b1;
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got out_exp %0h expected no result", bus.out_exp);
        end else begin
          e = sb.pop_front();
          chk("out_exp",    32'(bus.out_exp),    32'(e.e));
          chk("big_frac",   32'(bus.big_frac),   32'(e.bf));
          chk("small_frac", 32'(bus.small_frac), 32'(e.sf));
          chk("sticky",     32'(bus.sticky),     32'(e.st));
          chk("swapped",    32'(bus.swapped),    32'(e.sw));
          if (acc_q.size() > 0) chk("latency", 32'(cyc - acc_q.pop_front()), 32'd2);
          else begin
            tests++; fails++;
            $display("FAIL latency: got no accept record expected one");
          end
        end
        if (stream_mode) begin
          stream_cnt++;
          if (last_out >= 0) chk("stream_spacing", 32'(cyc - last_out), 32'd4);
          last_out = cyc;
        end
      end else if (!bus.out_valid) seen = 1'b0;
    end
  end

  task automatic send(input logic [EW-1:0] ae, input logic [FW-1:0] af,
                      input logic [EW-1:0] be, input logic [FW-1:0] bf,
                      input bit push, input exp_t e, input bit hold);
    int n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.in_ready) begin
      tests++; fails++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    bus.in_valid = 1'b1;
    bus.a_exp = ae; bus.a_frac = af; bus.b_exp = be; bus.b_frac = bf;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("wait_out_valid", {31'b0, bus.out_valid}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    exp_t snap;
    exp_t none;
    none = mk('0, '0, '0, 1'b0, 1'b0);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a_exp = '0; bus.b_exp = '0; bus.a_frac = '0; bus.b_frac = '0;
    #1;
    chk("rst_in_ready",   {31'b0, bus.in_ready},  32'd1);
    chk("rst_out_valid",  {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_exp",    32'(bus.out_exp),       32'd0);
    chk("rst_big_frac",   32'(bus.big_frac),      32'd0);
    chk("rst_small_frac", 32'(bus.small_frac),    32'd0);
    chk("rst_sticky",     {31'b0, bus.sticky},    32'd0);
    chk("rst_swapped",    {31'b0, bus.swapped},   32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed pairs, hand-computed expectations.
    send(8'd10,  18'h20000, 8'd7,   18'h30001, 1'b1, mk(8'd10,  18'h20000, 18'h06000, 1'b1, 1'b0), 1'b0);
    send(8'd5,   18'h3FFFF, 8'd25,  18'h20000, 1'b1, mk(8'd25,  18'h20000, 18'h00000, 1'b1, 1'b1), 1'b0);
    send(8'd100, 18'h10000, 8'd100, 18'h3FFFF, 1'b1, mk(8'd100, 18'h10000, 18'h3FFFF, 1'b0, 1'b0), 1'b0);
    send(8'd20,  18'h3FFFF, 8'd19,  18'h00003, 1'b1, mk(8'd20,  18'h3FFFF, 18'h00001, 1'b1, 1'b0), 1'b0);
    send(8'd0,   18'h20001, 8'd17,  18'h00001, 1'b1, mk(8'd17,  18'h00001, 18'h00001, 1'b1, 1'b1), 1'b0);
    send(8'd18,  18'h00005, 8'd0,   18'h20000, 1'b1, mk(8'd18,  18'h00005, 18'h00000, 1'b1, 1'b0), 1'b0);
    send(8'd0,   18'h00000, 8'd255, 18'h12345, 1'b1, mk(8'd255, 18'h12345, 18'h00000, 1'b0, 1'b1), 1'b0);
    send(8'd9,   18'h00ABC, 8'd8,   18'h00000, 1'b1, mk(8'd9,   18'h00ABC, 18'h00000, 1'b0, 1'b0), 1'b0);
    drain();

    // Stall in HOLD: outputs stable, in_valid pulses ignored.
    bus.out_ready = 1'b0;
    send(8'd40, 18'h2AAAA, 8'd42, 18'h15555, 1'b1, mk(8'd42, 18'h15555, 18'h0AAAA, 1'b1, 1'b1), 1'b0);
    wait_valid();
    snap = mk(bus.out_exp, bus.big_frac, bus.small_frac, bus.sticky, bus.swapped);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.a_exp = 8'(i + 1); bus.a_frac = 18'h1234 + 18'(i);
      @(posedge clk); #1;
      chk("stall_out_valid",  {31'b0, bus.out_valid}, 32'd1);
      chk("stall_in_ready",   {31'b0, bus.in_ready},  32'd0);
      chk("stall_out_exp",    32'(bus.out_exp),       32'(snap.e));
      chk("stall_small_frac", 32'(bus.small_frac),    32'(snap.sf));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready",  {31'b0, bus.in_ready},  32'd1);
    chk("release_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("retain_big_frac",   32'(bus.big_frac),      32'(snap.bf));
    repeat (3) @(posedge clk); #1;
    chk("stall_no_extra", {31'b0, bus.out_valid}, 32'd0);

    // Reset while in SHIFT discards the pair.
    send(8'd30, 18'h3C000, 8'd28, 18'h3FFFF, 1'b0, none, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid",  {31'b0, bus.out_valid}, 32'd0);
    chk("midrst_in_ready",   {31'b0, bus.in_ready},  32'd1);
    chk("midrst_out_exp",    32'(bus.out_exp),       32'd0);
    chk("midrst_big_frac",   32'(bus.big_frac),      32'd0);
    chk("midrst_small_frac", 32'(bus.small_frac),    32'd0);
    chk("midrst_flags",      {30'b0, bus.sticky, bus.swapped}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("postrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    send(8'd3, 18'h00010, 8'd7, 18'h3FFF0, 1'b1, mk(8'd7, 18'h3FFF0, 18'h00001, 1'b0, 1'b1), 1'b0);
    drain();

    // Streaming: in_valid and out_ready held high, three pairs.
    stream_mode = 1'b1; last_out = -1; stream_cnt = 0;
    send(8'd12, 18'h30000, 8'd10, 18'h0000F, 1'b1, mk(8'd12, 18'h30000, 18'h00003, 1'b1, 1'b0), 1'b1);
    send(8'd1,  18'h00001, 8'd2,  18'h20000, 1'b1, mk(8'd2,  18'h20000, 18'h00000, 1'b1, 1'b1), 1'b1);
    send(8'd64, 18'h11111, 8'd64, 18'h22222, 1'b1, mk(8'd64, 18'h11111, 18'h22222, 1'b0, 1'b0), 1'b0);
    drain();
    repeat (4) @(posedge clk); #1;
    chk("stream_count", 32'(stream_cnt), 32'd3);
    stream_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/align_scheduler.md
ALIGN_SCHEDULER -- requirements
Module: align_scheduler

Interface
REQ-001 Parameter FRAC_W, default 18, fraction width including hidden bit.
REQ-002 Parameter EXP_W, default 8, exponent width.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-005 Port in_valid  input  1  operand pair valid.
REQ-006 Port in_ready  output  1  block can accept a pair; high only in IDLE.
REQ-007 Port a_exp / b_exp  input  EXP_W each  operand exponents, unsigned.
REQ-008 Port a_frac / b_frac  input  FRAC_W each  operand fractions.
REQ-009 Port out_valid  output  1  aligned result valid; high only in HOLD.
REQ-010 Port out_ready  input  1  consumer accepts result.
REQ-011 Port out_exp  output  EXP_W  larger exponent, i.e. common exponent after alignment.
REQ-012 Port big_frac  output  FRAC_W  fraction of the larger-exponent operand, unshifted.
REQ-013 Port small_frac  output  FRAC_W  other fraction, logically right-shifted by the exponent difference.
REQ-014 Port sticky  output  1  OR of all bits shifted out of small_frac.
REQ-015 Port swapped  output  1  high when the b operand supplied big_frac.

Function
REQ-016 The block SHALL implement a 4-state FSM: IDLE, CMP, SHIFT, HOLD.
REQ-017 IDLE: in_ready=1; in_valid=1 at an edge captures a_*/b_* into registers and moves to CMP; otherwise remain in IDLE.
REQ-018 CMP (one cycle): if b_exp > a_exp, swap=1 and big=b; else swap=0 and big=a (equal exponents never swap). Register diff = big_exp - small_exp as an unsigned EXP_W value; go to SHIFT.
REQ-019 SHIFT (one cycle): drive the internal combinational logical right shifter with the registered small fraction and diff; register the result into small_frac and the computed sticky; go to HOLD.
REQ-020 Shifter rule: diff=0 gives the fraction unchanged. 1 <= diff <= FRAC_W-1 gives zero-fill from the MSB side. diff >= FRAC_W gives all zeros, with sticky = OR of the whole original fraction.
REQ-021 sticky SHALL be 0 when diff=0.
REQ-022 HOLD: out_valid=1 and all result outputs stable. out_ready=1 at an edge returns to IDLE; otherwise remain in HOLD indefinitely.
REQ-023 Latency: pair accepted at edge k gives out_valid=1 after edge k+2. Maximum throughput is one pair per 4 cycles (out_ready held high).
REQ-024 in_valid SHALL be ignored outside IDLE. Inputs changing after capture SHALL NOT affect the in-flight result.
REQ-025 Result outputs SHALL hold their last values after leaving HOLD until the next SHIFT update.
REQ-026 out_valid and in_ready SHALL never be high in the same cycle.

Reset
REQ-027 rst_n low SHALL immediately force: state=IDLE, out_valid=0, in_ready=1, out_exp=0, big_frac=0, small_frac=0, sticky=0, swapped=0, and all internal registers to 0.
REQ-028 Reset asserted in any state, including mid-operation, SHALL discard the in-flight pair with no output produced.
REQ-029 The first capture after reset release SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-030 a_exp=10, a_frac=0x20000, b_exp=7, b_frac=0x30001 -> out_exp=10, big_frac=0x20000, small_frac=0x06000, sticky=1, swapped=0, out_valid 2 edges after accept.
REQ-031 a_exp=5, a_frac=0x3FFFF, b_exp=25, b_frac=0x20000 -> swapped=1, out_exp=25, big_frac=0x20000, small_frac=0, sticky=1 (diff=20 >= 18).
REQ-032 a_exp=b_exp=100, a_frac=0x10000, b_frac=0x3FFFF -> swapped=0, small_frac=0x3FFFF, sticky=0.
REQ-033 out_ready low for 5 cycles in HOLD -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready high -> IDLE and in_ready=1 after that edge.
REQ-034 rst_n low during SHIFT -> out_valid stays 0, all outputs 0, in_ready=1; a new pair after release produces the correct result.
REQ-035 in_valid and out_ready held high with 3 queued pairs -> exactly 3 results, each 4 cycles apart, each matching its pair.
